mdpt_update_arbiter: RTL
========================

# mdpt_update_arbiter

Shares the single mdpt Dep Update 0 port between two dependence-training sources: load-pipeline violation reports (req0, always dep_truth=1) and commit-time training reports (req1, explicit dep_truth). Requests are accepted over valid/ready handshakes into a small FIFO, with round-robin priority when space is scarce. The FIFO drains one update per cycle into the mdpt, which has no backpressure. The block sits between the LSQ/commit logic and the mdpt instance.

## Interface
- MDPT_UPD_FIFO_DEPTH, default 4: FIFO entries; power of 2, minimum 2.
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  asynchronous active-low reset.
- req0_valid  in  1  violation report present.
- req0_full_PC  in  32  start PC of the violating load.
- req0_ASID  in  ASID_WIDTH  ASID of the report.
- req0_ready  out  1  req0 accepted this cycle when req0_valid=1.
- req1_valid  in  1  training report present.
- req1_full_PC  in  32  start PC of the trained load.
- req1_ASID  in  ASID_WIDTH  ASID of the report.
- req1_dep_truth  in  1  observed dependence outcome.
- req1_ready  out  1  req1 accepted this cycle when req1_valid=1.
- flush  in  1  drop all queued updates (ASID/context switch).
- dep_update0_valid  out  1  to mdpt.
- dep_update0_start_full_PC  out  32  to mdpt.
- dep_update0_ASID  out  ASID_WIDTH  to mdpt.
- dep_update0_dep_truth  out  1  to mdpt.

## Operation
- State: circular FIFO of {full_PC, ASID, dep_truth}; head ptr, tail ptr (log2 DEPTH bits, wrap naturally); count (log2 DEPTH + 1 bits); rr_ptr (0 = req0 priority).
- Drain: dep_update0_* driven combinationally from the head entry; dep_update0_valid = (count != 0) && !flush. The head pops every cycle dep_update0_valid=1; there is no stall input.
- free = DEPTH − count + (dep_update0_valid ? 1 : 0); this credits the same-cycle pop.
- Grant (ready may depend on valid):
  - flush=1: both ready=0.
  - free ≥ 2: both ready=1.
  - free = 1 and both valid: only the rr_ptr side is ready; then rr_ptr toggles at the edge.
  - free = 1 and one valid: that side is ready.
  - free = 0: both ready=0.
- rr_ptr changes only on a contested single-slot grant.
- Enqueue: accepted requests are written at the tail. If both are accepted, req0 goes to tail and req1 to tail+1. req0 entries store dep_truth=1.
- count_next = count + enq_count − pop. This is exact, so the FIFO never over- or underflows.
- Flush: at the edge, head, tail and count are set to 0. rr_ptr and storage are unchanged. The head is not presented during the flush cycle.
- Reset: count, head, tail, rr_ptr and all storage are set to 0. All outputs are therefore 0, and req*_ready is 1 as soon as nRST deasserts. Reset mid-operation discards queued updates, and no partial update is emitted.

## Timing
- A request accepted at edge k appears on dep_update0 in the cycle after edge k at the earliest (1-cycle latency when the FIFO is empty). There is no same-cycle bypass.
- Throughput: 1 update/cycle out; up to 2 accepted/cycle while free ≥ 2.
- Full FIFO with a pop in progress: free=1, so one request is still accepted the same cycle.
- Pointer wrap-around at DEPTH−1 → 0 needs no special handling.
- Flush in the same cycle as valid requests: the requests are not accepted and must be held by the source.

## Structure
- Shared package core_types_pkg:
  - MDPT_UPD_FIFO_DEPTH constant.
  - typedef mdpt_update_t {full_PC[31:0], ASID[ASID_WIDTH-1:0], dep_truth}.
  - ASID_WIDTH already lives there.
- Single module mdpt_update_arbiter; no sub-module is needed.
- Its outputs connect directly to the mdpt dep_update0_* ports.

## Test plan
- Reset: nRST=0 with random inputs → all outputs 0, both ready=0 only while flush, else 1. Release → dep_update0_valid=0.
- Single request: req1 {PC=0x1000, ASID=0x05, truth=0} at edge k → cycle after k shows dep_update0 {1, 0x1000, 0x05, 0}; the next cycle shows valid=0.
- Dual accept order: req0 PC=0x2000 and req1 PC=0x3000 in the same cycle, empty FIFO → outputs 0x2000 (truth=1) then 0x3000 on consecutive cycles.
- Round-robin at full: DEPTH=4, hold both valid continuously. After fill, grants alternate req0, req1, req0… one per cycle. count stays 4, and dep_update0_valid stays 1 every cycle.
- Flush: 3 entries queued, flush=1 for one cycle → dep_update0_valid=0 that cycle and the next. A request after flush emerges with PC exactly as sent; no stale entries appear.
- Reset mid-stream: 4 queued, pulse nRST low asynchronously mid-cycle → outputs go 0 immediately, and no queued update appears after release.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core types: ASID width, mdpt update FIFO sizing and the update record
// carried from the dependence-training sources to the mdpt.
package core_types_pkg;

   localparam int ASID_WIDTH          = 9;
   localparam int MDPT_UPD_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [31:0]           full_PC;
      logic [ASID_WIDTH-1:0] ASID;
      logic                  dep_truth;
   } mdpt_update_t;

endpackage

// File: rtl/mdpt_update_arbiter.sv
// Arbitrates violation (req0) and commit-training (req1) reports into a small
// FIFO that drains one update per cycle into the mdpt Dep Update 0 port.
module mdpt_update_arbiter
   import core_types_pkg::*;
(
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  req0_valid,
   input  logic [31:0]           req0_full_PC,
   input  logic [ASID_WIDTH-1:0] req0_ASID,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [31:0]           req1_full_PC,
   input  logic [ASID_WIDTH-1:0] req1_ASID,
   input  logic                  req1_dep_truth,
   output logic                  req1_ready,
   input  logic                  flush,
   output logic                  dep_update0_valid,
   output logic [31:0]           dep_update0_start_full_PC,
   output logic [ASID_WIDTH-1:0] dep_update0_ASID,
   output logic                  dep_update0_dep_truth
);

   localparam int DEPTH = MDPT_UPD_FIFO_DEPTH;
   localparam int PTR_W = $clog2(DEPTH);

   mdpt_update_t     fifo_q [DEPTH];
   mdpt_update_t     fifo_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             rr_q, rr_d;

   logic             pop;
   logic [PTR_W:0]   free;
   logic             acc0, acc1;
   mdpt_update_t     head_entry;

   assign head_entry                = fifo_q[head_q];
   assign pop                       = (count_q != '0) && !flush;
   assign dep_update0_valid         = pop;
   assign dep_update0_start_full_PC = head_entry.full_PC;
   assign dep_update0_ASID          = head_entry.ASID;
   assign dep_update0_dep_truth     = head_entry.dep_truth;

   // The slot freed by this cycle's pop is available to this cycle's enqueue.
   assign free = (PTR_W+1)'(DEPTH) - count_q + (PTR_W+1)'(pop);

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!flush) begin
         if (free >= (PTR_W+1)'(2)) begin
            req0_ready = 1'b1;
            req1_ready = 1'b1;
         end else if (free == (PTR_W+1)'(1)) begin
            req0_ready = !req1_valid || !rr_q;
            req1_ready = !req0_valid || rr_q;
         end
      end
   end

   assign acc0 = req0_valid && req0_ready;
   assign acc1 = req1_valid && req1_ready;

   always_comb begin
      fifo_d  = fifo_q;
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(acc0) + PTR_W'(acc1);
      count_d = count_q + (PTR_W+1)'(acc0) + (PTR_W+1)'(acc1) - (PTR_W+1)'(pop);
      rr_d    = rr_q;
      if (acc0) begin
         fifo_d[tail_q] = '{full_PC: req0_full_PC, ASID: req0_ASID, dep_truth: 1'b1};
      end
      if (acc1) begin
         fifo_d[tail_q + PTR_W'(acc0)] =
            '{full_PC: req1_full_PC, ASID: req1_ASID, dep_truth: req1_dep_truth};
      end
      if (!flush && free == (PTR_W+1)'(1) && req0_valid && req1_valid) begin
         rr_d = !rr_q;
      end
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rr_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rr_q    <= rr_d;
         fifo_q  <= fifo_d;
      end
   end

endmodule
